// File: rtl/pf_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered wr_vld/rd_vld and a registered head word.
// Define PF_FIFO_STATUS_EN to add the almost_full/almost_empty/ovf/udf status outputs.
module pf_sync_fifo #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 8,
    parameter int AF_LEVEL    = (1 << DEPTH_WIDTH) - 4,
    parameter int AE_LEVEL    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_vld,
    input  logic                   rd_en,
    output logic                   rd_vld,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DEPTH_WIDTH:0]   level
`ifdef PF_FIFO_STATUS_EN
    ,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   ovf,
    output logic                   udf
`endif
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] LVL_FULL = (DEPTH_WIDTH+1)'(DEPTH);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 1152) begin : g_bad_data_width
        $error("pf_sync_fifo: DATA_WIDTH out of range");
    end
    if (DEPTH_WIDTH < 2 || DEPTH_WIDTH > 12) begin : g_bad_depth_width
        $error("pf_sync_fifo: DEPTH_WIDTH out of range");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_levels
        $error("pf_sync_fifo: AF_LEVEL/AE_LEVEL out of range");
    end

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [DEPTH_WIDTH:0]   r_level;
    logic                   r_wr_vld;
    logic                   r_rd_vld;
    logic [DATA_WIDTH-1:0]  r_rd_data;

    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic [DEPTH_WIDTH-1:0] w_rd_ptr_next;
    logic [DEPTH_WIDTH:0]   w_level_next;
    logic                   w_rd_vld_next;
    logic [DATA_WIDTH-1:0]  w_head;

    assign w_wr_acc      = wr_en & r_wr_vld;
    assign w_rd_acc      = rd_en & r_rd_vld;
    assign w_rd_ptr_next = w_rd_acc ? (r_rd_ptr + DEPTH_WIDTH'(1)) : r_rd_ptr;

    always_comb begin
        w_level_next = r_level;
        if (w_wr_acc && !w_rd_acc) begin
            w_level_next = r_level + (DEPTH_WIDTH+1)'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_level_next = r_level - (DEPTH_WIDTH+1)'(1);
        end
    end

    // A word written into an empty FIFO waits one edge before it is presented;
    // a read+write at level 1 forwards the incoming word so the stream has no bubble.
    assign w_rd_vld_next = (r_level != '0) && (w_level_next != '0);
    assign w_head = (w_wr_acc && (w_rd_ptr_next == r_wr_ptr)) ? wr_data : r_mem[w_rd_ptr_next];

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_wr_vld  <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_WIDTH'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_level  <= w_level_next;
            r_wr_vld <= (w_level_next < LVL_FULL);
            r_rd_vld <= w_rd_vld_next;
            if (w_rd_vld_next) begin
                r_rd_data <= w_head;
            end
        end
    end

    assign wr_vld  = r_wr_vld;
    assign rd_vld  = r_rd_vld;
    assign rd_data = r_rd_data;
    assign level   = r_level;

`ifdef PF_FIFO_STATUS_EN
    logic r_almost_full;
    logic r_almost_empty;
    logic r_ovf;
    logic r_udf;

    // ovf/udf are sticky and only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_ovf          <= 1'b0;
            r_udf          <= 1'b0;
        end else begin
            r_almost_full  <= (int'(w_level_next) >= AF_LEVEL);
            r_almost_empty <= (int'(w_level_next) <= AE_LEVEL);
            r_ovf          <= r_ovf | (wr_en & ~r_wr_vld);
            r_udf          <= r_udf | (rd_en & ~r_rd_vld);
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign ovf          = r_ovf;
    assign udf          = r_udf;
`endif

endmodule

// File: doc/pf_sync_fifo.md
PF_SYNC_FIFO -- requirements
Module: pf_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits (legal 1..1152).
REQ-002 SHALL have parameter DEPTH_WIDTH, default 8, log2 of capacity (legal 2..12); capacity DEPTH = 2^DEPTH_WIDTH words.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, almost-full threshold (used only with PF_FIFO_STATUS_EN).
REQ-004 SHALL have parameter AE_LEVEL, default 4, almost-empty threshold (used only with PF_FIFO_STATUS_EN).
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH, write word.
REQ-009 SHALL have port wr_vld, output, 1, space available; a write is accepted on an edge where wr_en=1 and wr_vld=1.
REQ-010 SHALL have port rd_en, input, 1, read acknowledge; a read is accepted on an edge where rd_en=1 and rd_vld=1.
REQ-011 SHALL have port rd_vld, output, 1, rd_data holds the oldest word (prefetch / first-word-fall-through).
REQ-012 SHALL have port rd_data, output, DATA_WIDTH, head word.
REQ-013 SHALL have port level, output, DEPTH_WIDTH+1, words stored, including the head word.

Function
REQ-014 level SHALL increment on accepted write only, decrement on accepted read only, and hold on both or neither; range 0..DEPTH.
REQ-015 wr_vld SHALL be registered and equal (next level < DEPTH); a full FIFO with simultaneous rd_en and wr_en accepts only the read, and wr_vld rises after that edge.
REQ-016 wr_en while wr_vld=0 SHALL be ignored, with no change to storage, pointers or level.
REQ-017 rd_en while rd_vld=0 SHALL be ignored; a simultaneous write into an empty FIFO is still accepted.
REQ-018 A write accepted at edge k into an empty FIFO SHALL produce rd_vld=1 with that word on rd_data after edge k+1 (latency 1).
REQ-019 After an accepted read with level>=2, the next word SHALL appear on rd_data after the same edge, with rd_vld held at 1 (no bubble, back-to-back reads at one word per clock).
REQ-020 When rd_vld=1 and rd_en=0, rd_data SHALL remain stable.
REQ-021 Write and read pointers SHALL be DEPTH_WIDTH bits wide and wrap modulo DEPTH with no loss or duplication of data.
REQ-022 Data order SHALL be strict FIFO; sustained simultaneous read and write at any level 1..DEPTH-1 SHALL keep level constant.

Reset
REQ-023 rst_n=0 SHALL immediately clear pointers and level, and force wr_vld=0, rd_vld=0, rd_data=0; stored data is discarded, including when asserted mid-transfer.
REQ-024 wr_vld SHALL go to 1 on the first rising clk edge after rst_n deasserts; no write is accepted on that edge.

Configuration
REQ-025 With macro PF_FIFO_STATUS_EN defined, the block SHALL add outputs almost_full (level>=AF_LEVEL), almost_empty (level<=AE_LEVEL), ovf (sticky: wr_en while wr_vld=0) and udf (sticky: rd_en while rd_vld=0). All four are registered, reset to almost_empty=1 and the others 0, and are cleared only by rst_n.
REQ-026 Without PF_FIFO_STATUS_EN, these four ports and their logic SHALL be absent; all other behaviour is identical.

Verification (DATA_WIDTH=16, DEPTH_WIDTH=4)
REQ-027 Reset, then write 0x1234 at edge 1 -> rd_vld=1, rd_data=0x1234, level=1 after edge 2.
REQ-028 Write 16 words 0..15, then wr_en with 0xFFFF -> wr_vld=0, level=16, 0xFFFF dropped, ovf=1 (with macro); reading all 16 returns 0..15 in order.
REQ-029 At level 16, rd_en=1 and wr_en=1 on one edge -> read accepted, write ignored, level=15, wr_vld=1 after the edge.
REQ-030 Continuous writes and reads with rd_en held high for 40 words -> output in order, pointers wrap twice, no rd_vld bubbles once level>=2, level constant.
REQ-031 rd_en on an empty FIFO -> no state change, udf=1 (with macro); rst_n pulsed low at level 7 -> level=0, rd_vld=0, wr_vld=0 immediately, wr_vld=1 one edge after release.
